ex_div_stage: RTL

- Execute stage of the RV32 core, between the ID/EX pipeline register and the register file write port.
- Computes single-cycle RV32I ALU results.
- Runs RV32M DIV/DIVU/REM/REMU on a 32-iteration restoring divider FSM, stalling upstream while it works.
- Drives reg_waddr_o/reg_wdata_o/reg_wen_o straight into the register file's write/bypass port.

---
 rtl/ex_div_stage_if.sv | 30 +++
 rtl/ex_div_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_stage_if.sv
// ID/EX operand bundle into the execute stage plus the regfile write
// and stall signals back out; master = upstream/driver, slave = stage.
interface ex_div_stage_if;
   logic [31:0] inst_i;
   logic [31:0] op1_i;
   logic [31:0] op2_i;
   logic [4:0]  rd_addr_i;
   logic        reg_wen_i;
   logic        valid_i;
   logic        flush_i;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;
   logic        reg_wen_o;
   logic        hold_o;
   logic        busy_o;

   modport master (
      output inst_i, op1_i, op2_i, rd_addr_i,
      output reg_wen_i, valid_i, flush_i,
      input  reg_waddr_o, reg_wdata_o, reg_wen_o,
      input  hold_o, busy_o
   );

   modport slave (
      input  inst_i, op1_i, op2_i, rd_addr_i,
      input  reg_wen_i, valid_i, flush_i,
      output reg_waddr_o, reg_wdata_o, reg_wen_o,
      output hold_o, busy_o
   );
endinterface

// File: rtl/ex_div_stage.sv
// RV32 execute stage: single-cycle RV32I ALU plus a 32-step restoring
// divider (DIV/DIVU/REM/REMU). Ports: clk, rst (sync, active-low), bus
// (ID/EX operands in; regfile waddr/wdata/wen, hold and busy out).
module ex_div_stage #(
   parameter int XLEN       = 32,
   parameter int DIV_CYCLES = 32
) (
   input  logic           clk,
   input  logic           rst,
   ex_div_stage_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   localparam logic [4:0] LAST = 5'(DIV_CYCLES - 1);

   state_t            r_state;
   logic [4:0]        r_cnt;
   logic [XLEN-1:0]   r_quo;
   logic [XLEN-1:0]   r_rem;
   logic [XLEN-1:0]   r_dvs;
   logic [XLEN-1:0]   r_res;
   logic [4:0]        r_rd;
   logic              r_wen;
   logic              r_is_rem;
   logic              r_neg_q;
   logic              r_neg_r;

   logic [6:0]        w_opc;
   logic [2:0]        w_f3;
   logic [6:0]        w_f7;
   logic [4:0]        w_shamt;
   logic              w_is_op;
   logic              w_is_opi;
   logic              w_is_lui;
   logic              w_is_auipc;
   logic              w_is_div;
   logic              w_base;
   logic              w_alt;
   logic              w_f7_ok;
   logic              w_alu_ok;
   logic [XLEN-1:0]   w_alu_res;
   logic [XLEN-1:0]   w_op1;
   logic [XLEN-1:0]   w_op2;

   logic              w_sgn;
   logic              w_s1;
   logic              w_s2;
   logic [XLEN-1:0]   w_abs1;
   logic [XLEN-1:0]   w_abs2;
   logic              w_dz;
   logic              w_ovf;
   logic [XLEN-1:0]   w_spec;
   logic              w_acc;

   logic [XLEN:0]     w_sh;
   logic [XLEN:0]     w_diff;
   logic              w_ge;
   logic [XLEN-1:0]   w_rem_n;
   logic [XLEN-1:0]   w_quo_n;
   logic [XLEN-1:0]   w_fin;
   logic              w_unused;

   assign w_op1      = bus.op1_i;
   assign w_op2      = bus.op2_i;
   assign w_opc      = bus.inst_i[6:0];
   assign w_f3       = bus.inst_i[14:12];
   assign w_f7       = bus.inst_i[31:25];
   assign w_shamt    = w_op2[4:0];
   assign w_is_op    = (w_opc == 7'b0110011);
   assign w_is_opi   = (w_opc == 7'b0010011);
   assign w_is_lui   = (w_opc == 7'b0110111);
   assign w_is_auipc = (w_opc == 7'b0010111);
   assign w_base     = (w_f7 == 7'b0000000);
   assign w_alt      = (w_f7 == 7'b0100000);
   assign w_is_div   = w_is_op && (w_f7 == 7'b0000001) && w_f3[2];
   assign w_unused   = ^{bus.inst_i[24:15], bus.inst_i[11:7]};

   // OP-IMM only constrains funct7 on shifts; other funct7 bits are imm
   always_comb begin
      w_f7_ok = 1'b0;
      if (w_is_op) begin
         w_f7_ok = w_base ||
                   (w_alt && (w_f3 == 3'b000 || w_f3 == 3'b101));
      end else if (w_f3 == 3'b001) begin
         w_f7_ok = w_base;
      end else if (w_f3 == 3'b101) begin
         w_f7_ok = w_base || w_alt;
      end else begin
         w_f7_ok = 1'b1;
      end
   end

   always_comb begin
      w_alu_res = '0;
      w_alu_ok  = 1'b0;
      unique case (1'b1)
         w_is_lui: begin
            w_alu_res = w_op2;
            w_alu_ok  = 1'b1;
         end
         w_is_auipc: begin
            w_alu_res = w_op1 + w_op2;
            w_alu_ok  = 1'b1;
         end
         w_is_op, w_is_opi: begin
            w_alu_ok = w_f7_ok;
            case (w_f3)
               3'b000: w_alu_res = (w_is_op && w_alt) ?
                                   w_op1 - w_op2 : w_op1 + w_op2;
               3'b001: w_alu_res = w_op1 << w_shamt;
               3'b010: w_alu_res = {{(XLEN-1){1'b0}},
                                   $signed(w_op1) < $signed(w_op2)};
               3'b011: w_alu_res = {{(XLEN-1){1'b0}}, w_op1 < w_op2};
               3'b100: w_alu_res = w_op1 ^ w_op2;
               3'b101: w_alu_res = w_alt ?
                                   XLEN'($signed(w_op1) >>> w_shamt) :
                                   w_op1 >> w_shamt;
               3'b110: w_alu_res = w_op1 | w_op2;
               default: w_alu_res = w_op1 & w_op2;
            endcase
         end
         default: ;
      endcase
   end

   // funct3[0]=1 is unsigned, funct3[1]=1 selects remainder
   assign w_sgn  = ~w_f3[0];
   assign w_s1   = w_sgn & w_op1[XLEN-1];
   assign w_s2   = w_sgn & w_op2[XLEN-1];
   assign w_abs1 = w_s1 ? -w_op1 : w_op1;
   assign w_abs2 = w_s2 ? -w_op2 : w_op2;
   assign w_dz   = (w_op2 == '0);
   assign w_ovf  = w_sgn && (w_op1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (w_op2 == '1);
   assign w_spec = w_dz ? (w_f3[1] ? w_op1 : '1) :
                   (w_f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
   assign w_acc  = (r_state == S_IDLE) && bus.valid_i &&
                   !bus.flush_i && w_is_div;

   // rem < divisor, so the shifted value always fits in XLEN+1 bits
   // and the borrow bit alone decides the quotient bit
   assign w_sh    = {r_rem, r_quo[XLEN-1]};
   assign w_diff  = w_sh - {1'b0, r_dvs};
   assign w_ge    = ~w_diff[XLEN];
   assign w_rem_n = w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
   assign w_quo_n = {r_quo[XLEN-2:0], w_ge};
   assign w_fin   = r_is_rem ? (r_neg_r ? -w_rem_n : w_rem_n) :
                               (r_neg_q ? -w_quo_n : w_quo_n);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_dvs    <= '0;
         r_res    <= '0;
         r_rd     <= '0;
         r_wen    <= 1'b0;
         r_is_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_acc) begin
                  r_rd     <= bus.rd_addr_i;
                  r_wen    <= bus.reg_wen_i && (bus.rd_addr_i != 5'd0);
                  r_is_rem <= w_f3[1];
                  r_neg_q  <= w_s1 ^ w_s2;
                  r_neg_r  <= w_s1;
                  r_cnt    <= '0;
                  if (w_dz || w_ovf) begin
                     r_res   <= w_spec;
                     r_state <= S_DONE;
                  end else begin
                     r_quo   <= w_abs1;
                     r_rem   <= '0;
                     r_dvs   <= w_abs2;
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (bus.flush_i) begin
                  r_state <= S_IDLE;
               end else begin
                  r_quo <= w_quo_n;
                  r_rem <= w_rem_n;
                  r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == LAST) begin
                     r_res   <= w_fin;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.reg_waddr_o = '0;
      bus.reg_wdata_o = '0;
      bus.reg_wen_o   = 1'b0;
      bus.hold_o      = 1'b0;
      if (rst) begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.valid_i) begin
                  if (w_is_div) begin
                     bus.hold_o = !bus.flush_i;
                  end else begin
                     bus.reg_waddr_o = bus.rd_addr_i;
                     bus.reg_wdata_o = w_alu_res;
                     bus.reg_wen_o   = w_alu_ok && bus.reg_wen_i &&
                                       (bus.rd_addr_i != 5'd0) &&
                                       !bus.flush_i;
                  end
               end
            end
            S_BUSY: bus.hold_o = !bus.flush_i;
            S_DONE: begin
               if (!bus.flush_i) begin
                  bus.reg_waddr_o = r_rd;
                  bus.reg_wdata_o = r_res;
                  bus.reg_wen_o   = r_wen;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy_o = rst && (r_state != S_IDLE);

endmodule
